i2s_dac_tx: RTL and testbench
=============================

// Module: i2s_dac_tx
// PURPOSE
//  Transmit side of the WM8731 audio link: serializes 16-bit PCM samples onto AUD_DACDAT
//  in I2S format, with the codec as BCLK/DACLRCK master. Samples enter via a valid/ready
//  FIFO in the clk domain, e.g. a tone or click generator driven by beat_pulse.
//  Mono: each popped sample goes out on both left and right slots.
// PARAMETERS
//  W            16   sample width in bits (MSB first on the wire)
//  FIFO_DEPTH   8    input FIFO entries; power of 2, >= 2
//  SYNC_STAGES  2    flip-flop synchronizer depth for bclk and daclrck
// PORTS
//  clk        in   1  system clock (CLOCK_50); must be >= 4x bclk frequency
//  reset      in   1  asynchronous, active-high reset
//  s_valid    in   1  input sample valid
//  s_ready    out  1  FIFO not full
//  s_data     in   W  signed PCM sample
//  bclk       in   1  AUD_BCLK from codec (asynchronous to clk)
//  daclrck    in   1  AUD_DACLRCK from codec; low = left, high = right
//  dacdat     out  1  AUD_DACDAT serial data to codec
//  underflow  out  1  one-cycle pulse: FIFO was empty at a left-slot start
// BEHAVIOUR
//  Reset values: dacdat=0, underflow=0, FIFO empty (s_ready=1), hold=0, state IDLE.
//  Reset asserted mid-shift takes effect immediately and discards the FIFO contents.
//  Synchronization: bclk and daclrck each pass through SYNC_STAGES FFs.
//   - bfall = bclk falling edge of the synced signal.
//   - lr_edge = any daclrck toggle; lr_fall = high->low toggle.
//  FIFO: push when s_valid && s_ready; s_ready = !full (combinational from count).
//   - No push when full.
//   - No empty bypass: a push and a pop in the same cycle on an empty FIFO count as underflow.
//  Pop happens only on lr_fall:
//   - FIFO non-empty: hold <= head, pop.
//   - FIFO empty: hold <= 0, underflow pulses in that cycle.
//  Rising daclrck edge (right slot) reuses hold unchanged.
//  State machine:
//   - IDLE: dacdat=0; on the first lr_fall go to SHIFT. An initial rising edge is ignored.
//   - SHIFT: on entry, sh <= word (the value popped into hold, or hold for right) and bitcnt <= W.
//     Each later bfall: dacdat <= sh[W-1], sh <<= 1, bitcnt--. After the W-th bit go to PAD.
//   - PAD: on the next bfall, dacdat <= 0 and holds until lr_edge, then go to SHIFT.
//  Timing: MSB is driven on the first bfall after the LRCK edge, so the codec samples it
//   on the 2nd rising BCLK (standard I2S 1-bit delay).
//  Simultaneous lr_edge and bfall: lr_edge wins (load only, no shift that cycle).
//  Short slot (lr_edge before W bits are sent): remaining bits are dropped and the new slot
//   loads. dacdat keeps its current bit until the next bfall.
//  Latency: from push into an empty FIFO to MSB on the wire is the next lr_fall plus one bfall.
//  Sample order through the FIFO is strictly preserved; wrap-around uses log2(FIFO_DEPTH)-bit
//   pointers and a (log2+1)-bit count.
// CONFIGURATION
//  DAC_TX_UNDERFLOW_CNT_EN defined:
//   - Adds port underflow_count (out, 16): counts underflow pulses.
//   - Saturates at 16'hFFFF; reset value 0.
//  DAC_TX_UNDERFLOW_CNT_EN undefined:
//   - Port and counter are absent.
//   - The underflow pulse is still generated.
// TESTING
//  1 Push 16'hA5C3, clk=50 MHz, bclk=clk/16, daclrck toggling every 32 bclk
//    -> after lr_fall, dacdat on bfalls 1..16 = 1010010111000011, then 0.
//    -> The right slot repeats the same 16 bits.
//  2 No pushes, lr_fall -> underflow high exactly 1 cycle; dacdat 0 in both slots;
//    with the macro, underflow_count increments 0->1.
//  3 Push 8 words 1..8 back-to-back -> s_ready low after the 8th push.
//    -> At the next lr_fall, s_ready high 1 cycle later; words go out in order 1..8 on successive left slots.
//  4 Assert reset during bit 7 of a slot -> dacdat=0 asynchronously, s_ready=1, FIFO empty.
//    -> After release, output stays 0 until the next lr_fall.
//  5 daclrck toggles after 10 bclk with word 16'hFFFF -> 10 ones are sent, then the next slot's MSB follows.
//    -> No bit slip.
//  6 Macro on, force 65537 underflows (preload the counter via force) -> underflow_count holds 16'hFFFF.

Source files
------------

// File: rtl/i2s_dac_tx.sv
// I2S transmit path for the WM8731 DAC: FIFO-buffered mono samples serialized on codec-mastered BCLK/LRCK.
// Optional macro DAC_TX_UNDERFLOW_CNT_EN adds a saturating 16-bit underflow_count output.
module i2s_dac_tx #(
    parameter int W           = 16,
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_data,
    input  logic         bclk,
    input  logic         daclrck,
    output logic         dacdat,
    output logic         underflow
`ifdef DAC_TX_UNDERFLOW_CNT_EN
    ,
    output logic [15:0]  underflow_count
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, PAD} state_e;

    // The top bit of each chain is a delayed copy of the synchronized level, used for edge detection.
    logic [SYNC_STAGES:0] bclkSync_q;
    logic [SYNC_STAGES:0] lrSync_q;
    logic                 bFall;
    logic                 lrEdge;
    logic                 lrFall;

    logic [W-1:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0] wrPtr_q;
    logic [AW-1:0] rdPtr_q;
    logic [AW:0]   count_q;
    logic          empty;
    logic          push;
    logic          pop;

    logic [W-1:0]  hold_q;
    logic [W-1:0]  loadWord;
    logic          underflow_q;

    state_e        state_q, state_d;
    logic [W-1:0]  sh_q, sh_d;
    logic [CW-1:0] bitCnt_q, bitCnt_d;
    logic          dacdat_q, dacdat_d;

    assign bFall  = bclkSync_q[SYNC_STAGES] & ~bclkSync_q[SYNC_STAGES-1];
    assign lrEdge = lrSync_q[SYNC_STAGES] ^ lrSync_q[SYNC_STAGES-1];
    assign lrFall = lrSync_q[SYNC_STAGES] & ~lrSync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bclkSync_q <= '0;
            lrSync_q   <= '0;
        end else begin
            bclkSync_q <= {bclkSync_q[SYNC_STAGES-1:0], bclk};
            lrSync_q   <= {lrSync_q[SYNC_STAGES-1:0], daclrck};
        end
    end

    // Pops look only at the registered count, so a same-cycle push cannot rescue an empty FIFO.
    assign empty   = (count_q == '0);
    assign s_ready = (count_q != (AW + 1)'(FIFO_DEPTH));
    assign push    = s_valid && s_ready;
    assign pop     = lrFall && !empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wrPtr_q] <= s_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wrPtr_q <= wrPtr_q + AW'(1);
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign loadWord = lrFall ? (empty ? '0 : mem_q[rdPtr_q]) : hold_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q      <= '0;
            underflow_q <= 1'b0;
        end else begin
            underflow_q <= lrFall && empty;
            if (lrFall) begin
                hold_q <= loadWord;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            sh_q     <= '0;
            bitCnt_q <= '0;
            dacdat_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sh_q     <= sh_d;
            bitCnt_q <= bitCnt_d;
            dacdat_q <= dacdat_d;
        end
    end

    // An LRCK edge always reloads the shifter and suppresses any shift in that cycle.
    always_comb begin
        state_d  = state_q;
        sh_d     = sh_q;
        bitCnt_d = bitCnt_q;
        dacdat_d = dacdat_q;
        case (state_q)
            IDLE: begin
                dacdat_d = 1'b0;
                if (lrFall) begin
                    state_d  = SHIFT;
                    sh_d     = loadWord;
                    bitCnt_d = CW'(W);
                end
            end
            SHIFT: begin
                if (lrEdge) begin
                    sh_d     = loadWord;
                    bitCnt_d = CW'(W);
                end else if (bFall) begin
                    dacdat_d = sh_q[W-1];
                    sh_d     = {sh_q[W-2:0], 1'b0};
                    bitCnt_d = bitCnt_q - CW'(1);
                    if (bitCnt_q == CW'(1)) begin
                        state_d = PAD;
                    end
                end
            end
            PAD: begin
                if (lrEdge) begin
                    state_d  = SHIFT;
                    sh_d     = loadWord;
                    bitCnt_d = CW'(W);
                end else if (bFall) begin
                    dacdat_d = 1'b0;
                end
            end
            default: begin
                state_d  = IDLE;
                dacdat_d = 1'b0;
            end
        endcase
    end

    assign dacdat    = dacdat_q;
    assign underflow = underflow_q;

`ifdef DAC_TX_UNDERFLOW_CNT_EN
    logic [15:0] ufCount_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ufCount_q <= '0;
        end else if (underflow_q && (ufCount_q != 16'hFFFF)) begin
            ufCount_q <= ufCount_q + 16'd1;
        end
    end

    assign underflow_count = ufCount_q;
`endif

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Directed bench for i2s_dac_tx: drives codec-style BCLK/LRCK and checks the serialized words slot by slot.
// Also exercises the saturating counter when built with DAC_TX_UNDERFLOW_CNT_EN.
module tb_i2s_dac_tx;
    localparam int W = 16;

    logic         clk     = 1'b0;
    logic         reset   = 1'b0;
    logic         s_valid = 1'b0;
    logic [W-1:0] s_data  = '0;
    logic         bclk    = 1'b0;
    logic         daclrck = 1'b1;
    logic         s_ready;
    logic         dacdat;
    logic         underflow;
`ifdef DAC_TX_UNDERFLOW_CNT_EN
    logic [15:0]  underflow_count;
`endif

    int total    = 0;
    int bad      = 0;
    int ufCycles = 0;

    i2s_dac_tx #(.W(W), .FIFO_DEPTH(8), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .bclk      (bclk),
        .daclrck   (daclrck),
        .dacdat    (dacdat),
        .underflow (underflow)
`ifdef DAC_TX_UNDERFLOW_CNT_EN
        ,
        .underflow_count (underflow_count)
`endif
    );

    // BCLK runs at clk/16 with a phase offset so its edges never coincide with clk edges.
    always #5 clk = ~clk;
    initial begin
        #3;
        forever #80 bclk = ~bclk;
    end

    always @(posedge clk) begin
        if (underflow === 1'b1) begin
            ufCycles = ufCycles + 1;
        end
    end

    task automatic pushWord(input logic [W-1:0] d);
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    // LRCK changes on a falling BCLK, as the codec does.
    task automatic startSlot(input logic lr);
        @(negedge bclk);
        daclrck = lr;
    endtask

    // cap[i] is the bit the codec sees on the i-th rising BCLK of the slot (cap[0] precedes the MSB).
    task automatic captureSlot(input int n, output logic [31:0] cap);
        cap = '0;
        for (int i = 0; i < n; i++) begin
            @(posedge bclk);
            cap[i] = dacdat;
        end
    endtask

    function automatic logic [W-1:0] slotWord(input logic [31:0] cap);
        logic [W-1:0] w;
        for (int j = 0; j < W; j++) begin
            w[W-1-j] = cap[1+j];
        end
        return w;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        #23;
        total++;
        if (dacdat !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_dacdat: got %b expected 0", dacdat);
        end
        total++;
        if (underflow !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_underflow: got %b expected 0", underflow);
        end
        total++;
        if (s_ready !== 1'b1) begin
            bad++; $display("[TB] FAIL reset_ready: got %b expected 1", s_ready);
        end
`ifdef DAC_TX_UNDERFLOW_CNT_EN
        total++;
        if (underflow_count !== 16'd0) begin
            bad++; $display("[TB] FAIL reset_count: got %h expected 0000", underflow_count);
        end
`endif
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_single_word();
        logic [31:0] cap;
        int          uf0;
        pushWord(16'hA5C3);
        uf0 = ufCycles;
        startSlot(1'b0);
        captureSlot(32, cap);
        total++;
        if (slotWord(cap) !== 16'hA5C3) begin
            bad++; $display("[TB] FAIL single_left_word: got %h expected a5c3", slotWord(cap));
        end
        total++;
        if (cap[31:17] !== 15'h0) begin
            bad++; $display("[TB] FAIL single_left_pad: got %h expected 0000", cap[31:17]);
        end
        startSlot(1'b1);
        captureSlot(32, cap);
        total++;
        if (slotWord(cap) !== 16'hA5C3) begin
            bad++; $display("[TB] FAIL single_right_word: got %h expected a5c3", slotWord(cap));
        end
        total++;
        if (cap[31:17] !== 15'h0) begin
            bad++; $display("[TB] FAIL single_right_pad: got %h expected 0000", cap[31:17]);
        end
        total++;
        if ((ufCycles - uf0) !== 0) begin
            bad++; $display("[TB] FAIL single_no_underflow: got %0d expected 0", ufCycles - uf0);
        end
    endtask

    task automatic test_underflow();
        logic [31:0] cap;
        int          uf0;
        uf0 = ufCycles;
        startSlot(1'b0);
        captureSlot(32, cap);
        total++;
        if (cap !== 32'h0) begin
            bad++; $display("[TB] FAIL underflow_left_zero: got %h expected 00000000", cap);
        end
        total++;
        if ((ufCycles - uf0) !== 1) begin
            bad++; $display("[TB] FAIL underflow_pulse_cycles: got %0d expected 1", ufCycles - uf0);
        end
        startSlot(1'b1);
        captureSlot(32, cap);
        total++;
        if (cap !== 32'h0) begin
            bad++; $display("[TB] FAIL underflow_right_zero: got %h expected 00000000", cap);
        end
`ifdef DAC_TX_UNDERFLOW_CNT_EN
        total++;
        if (underflow_count !== 16'd1) begin
            bad++; $display("[TB] FAIL underflow_count_one: got %h expected 0001", underflow_count);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [31:0] cap;
        int          uf0;
        int          waited;
        for (int k = 1; k <= 8; k++) begin
            pushWord(W'(k));
        end
        total++;
        if (s_ready !== 1'b0) begin
            bad++; $display("[TB] FAIL full_ready_low: got %b expected 0", s_ready);
        end
        // A ninth offer while full must be ignored.
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = 16'h0009;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        startSlot(1'b0);
        waited = 0;
        while (s_ready !== 1'b1 && waited < 6) begin
            @(posedge clk);
            #1;
            waited++;
        end
        total++;
        if (s_ready !== 1'b1) begin
            bad++; $display("[TB] FAIL ready_after_pop: got %b expected 1", s_ready);
        end
        captureSlot(32, cap);
        total++;
        if (slotWord(cap) !== 16'd1) begin
            bad++; $display("[TB] FAIL order_left_1: got %h expected 0001", slotWord(cap));
        end
        startSlot(1'b1);
        captureSlot(32, cap);
        total++;
        if (slotWord(cap) !== 16'd1) begin
            bad++; $display("[TB] FAIL order_right_1: got %h expected 0001", slotWord(cap));
        end
        for (int k = 2; k <= 8; k++) begin
            startSlot(1'b0);
            captureSlot(32, cap);
            total++;
            if (slotWord(cap) !== W'(k)) begin
                bad++; $display("[TB] FAIL order_left_%0d: got %h expected %h", k, slotWord(cap), W'(k));
            end
            startSlot(1'b1);
            captureSlot(32, cap);
        end
        uf0 = ufCycles;
        startSlot(1'b0);
        captureSlot(32, cap);
        total++;
        if (slotWord(cap) !== 16'h0) begin
            bad++; $display("[TB] FAIL drained_word: got %h expected 0000", slotWord(cap));
        end
        total++;
        if ((ufCycles - uf0) !== 1) begin
            bad++; $display("[TB] FAIL drained_underflow: got %0d expected 1", ufCycles - uf0);
        end
        startSlot(1'b1);
        captureSlot(32, cap);
    endtask

    task automatic test_reset_midslot();
        logic [31:0] cap;
        int          uf0;
        pushWord(16'hFFFF);
        pushWord(16'hFFFF);
        startSlot(1'b0);
        captureSlot(7, cap);
        @(negedge bclk);
        #50;
        total++;
        if (dacdat !== 1'b1) begin
            bad++; $display("[TB] FAIL midslot_bit7: got %b expected 1", dacdat);
        end
        reset = 1'b1;
        #1;
        total++;
        if (dacdat !== 1'b0) begin
            bad++; $display("[TB] FAIL midslot_reset_dacdat: got %b expected 0", dacdat);
        end
        total++;
        if (s_ready !== 1'b1) begin
            bad++; $display("[TB] FAIL midslot_reset_ready: got %b expected 1", s_ready);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        startSlot(1'b1);
        captureSlot(32, cap);
        total++;
        if (cap !== 32'h0) begin
            bad++; $display("[TB] FAIL post_reset_right_zero: got %h expected 00000000", cap);
        end
        uf0 = ufCycles;
        startSlot(1'b0);
        captureSlot(32, cap);
        total++;
        if (cap !== 32'h0) begin
            bad++; $display("[TB] FAIL post_reset_left_zero: got %h expected 00000000", cap);
        end
        total++;
        if ((ufCycles - uf0) !== 1) begin
            bad++; $display("[TB] FAIL post_reset_fifo_empty: got %0d expected 1", ufCycles - uf0);
        end
        startSlot(1'b1);
        captureSlot(32, cap);
    endtask

    task automatic test_short_slot();
        logic [31:0] cap;
        pushWord(16'hFFFF);
        pushWord(16'h1234);
        startSlot(1'b0);
        captureSlot(32, cap);
        total++;
        if (slotWord(cap) !== 16'hFFFF) begin
            bad++; $display("[TB] FAIL short_first_word: got %h expected ffff", slotWord(cap));
        end
        startSlot(1'b1);
        captureSlot(10, cap);
        total++;
        if (cap[9:1] !== 9'h1FF) begin
            bad++; $display("[TB] FAIL short_slot_ones: got %h expected 1ff", cap[9:1]);
        end
        startSlot(1'b0);
        captureSlot(32, cap);
        total++;
        if (cap[0] !== 1'b1) begin
            bad++; $display("[TB] FAIL short_held_bit: got %b expected 1", cap[0]);
        end
        total++;
        if (slotWord(cap) !== 16'h1234) begin
            bad++; $display("[TB] FAIL short_next_word: got %h expected 1234", slotWord(cap));
        end
        total++;
        if (cap[31:17] !== 15'h0) begin
            bad++; $display("[TB] FAIL short_next_pad: got %h expected 0000", cap[31:17]);
        end
        startSlot(1'b1);
        captureSlot(32, cap);
        total++;
        if (slotWord(cap) !== 16'h1234) begin
            bad++; $display("[TB] FAIL short_next_right: got %h expected 1234", slotWord(cap));
        end
    endtask

`ifdef DAC_TX_UNDERFLOW_CNT_EN
    task automatic test_saturate();
        logic [31:0] cap;
        force dut.ufCount_q = 16'hFFFE;
        @(posedge clk);
        #1;
        release dut.ufCount_q;
        startSlot(1'b0);
        captureSlot(32, cap);
        total++;
        if (underflow_count !== 16'hFFFF) begin
            bad++; $display("[TB] FAIL count_reach_max: got %h expected ffff", underflow_count);
        end
        startSlot(1'b1);
        captureSlot(32, cap);
        for (int k = 0; k < 2; k++) begin
            startSlot(1'b0);
            captureSlot(32, cap);
            startSlot(1'b1);
            captureSlot(32, cap);
        end
        total++;
        if (underflow_count !== 16'hFFFF) begin
            bad++; $display("[TB] FAIL count_saturated: got %h expected ffff", underflow_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_word();
        test_underflow();
        test_back_to_back();
        test_reset_midslot();
        test_short_slot();
`ifdef DAC_TX_UNDERFLOW_CNT_EN
        test_saturate();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
